xm23_dev_regs: RTL

//  Parametrised memory-mapped device register bank for the XM23 low-memory device space.

---
 rtl/xm23_dev_regs_if.sv | 32 +++
 rtl/xm23_dev_regs.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xm23_dev_regs_if.sv
// Bus bundle between the CPU/device side and the XM23 device register bank.
// The master drives strobes and device inputs; the slave (register bank) drives read data, tx and irq.
interface xm23_dev_regs_if #(
    parameter int NUM_DEV = 3
);
    logic [15:0]            cpu_addr;
    logic                   cpu_rd;
    logic                   cpu_wr;
    logic                   cpu_byte;
    logic [15:0]            cpu_wdata;
    logic                   cpu_hit;
    logic [15:0]            cpu_rdata;
    logic [NUM_DEV-1:0]     dev_rx_valid;
    logic [8*NUM_DEV-1:0]   dev_rx_data;
    logic [NUM_DEV-1:0]     dev_tx_valid;
    logic [8*NUM_DEV-1:0]   dev_tx_data;
    logic [NUM_DEV-1:0]     dev_tx_done;
    logic                   irq;
    logic [2:0]             irq_vect;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_byte, cpu_wdata,
        output dev_rx_valid, dev_rx_data, dev_tx_done,
        input  cpu_hit, cpu_rdata, dev_tx_valid, dev_tx_data, irq, irq_vect
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_byte, cpu_wdata,
        input  dev_rx_valid, dev_rx_data, dev_tx_done,
        output cpu_hit, cpu_rdata, dev_tx_valid, dev_tx_data, irq, irq_vect
    );
endinterface

// File: rtl/xm23_dev_regs.sv
// XM23 memory-mapped device register bank: NUM_DEV channels of {CSR, DATA} bytes with
// input/output handshakes, DBA/OF status and a lowest-index-first interrupt request.
module xm23_dev_regs #(
    parameter int          NUM_DEV   = 3,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [7:0]  IN_MASK   = 8'h01
) (
    input  logic             Clock,
    input  logic             Reset_n,
    xm23_dev_regs_if.slave   bus
);

    localparam logic [16:0] BANK_LO = {1'b0, BASE_ADDR};
    localparam logic [16:0] BANK_HI = {1'b0, BASE_ADDR} + 17'(2 * NUM_DEV);

    logic [NUM_DEV-1:0]             ie_q, ie_d;
    logic [NUM_DEV-1:0]             of_q, of_d;
    logic [NUM_DEV-1:0]             ena_q, ena_d;
    logic [NUM_DEV-1:0]             dba_q, dba_d;
    logic [NUM_DEV-1:0][7:0]        data_q, data_d;
    logic [NUM_DEV-1:0]             tx_valid_q, tx_valid_d;
    logic [15:0]                    rdata_q, rdata_d;
    logic                           irq_q, irq_d;
    logic [2:0]                     irq_vect_q, irq_vect_d;

    logic                           hit_s;
    logic [3:0]                     offset_s;
    logic [2:0]                     ch_s;
    logic                           odd_s;
    logic                           rd_s;
    logic                           wr_s;
    logic [NUM_DEV-1:0]             csr_sel_s;
    logic [NUM_DEV-1:0]             data_sel_s;
    logic [NUM_DEV-1:0]             rd_clr_s;
    logic [NUM_DEV-1:0]             dba_now_s;
    logic [NUM_DEV-1:0]             req_s;
    logic [7:0]                     csr_wbyte_s;
    logic [7:0]                     data_wbyte_s;
    logic [7:0]                     sel_csr_s;
    logic [7:0]                     sel_data_s;
    logic [8*NUM_DEV-1:0]           tx_data_s;

    function automatic logic [7:0] csr_byte(input logic ie, input logic io, input logic dba,
                                            input logic of, input logic ena);
        csr_byte = {3'b000, ena, of, dba, io, ie};
    endfunction

    // Address decode; the low nibble of the offset is enough to pick channel and byte lane.
    always_comb begin
        hit_s    = ({1'b0, bus.cpu_addr} >= BANK_LO) && ({1'b0, bus.cpu_addr} < BANK_HI);
        offset_s = bus.cpu_addr[3:0] - BASE_ADDR[3:0];
        ch_s     = offset_s[3:1];
        odd_s    = offset_s[0];
        rd_s     = bus.cpu_rd & hit_s;
        wr_s     = bus.cpu_wr & hit_s;
        csr_wbyte_s  = bus.cpu_wdata[7:0];
        data_wbyte_s = bus.cpu_byte ? bus.cpu_wdata[7:0] : bus.cpu_wdata[15:8];
        for (int i = 0; i < NUM_DEV; i++) begin
            csr_sel_s[i]  = (ch_s == 3'(i)) && (!bus.cpu_byte || !odd_s);
            data_sel_s[i] = (ch_s == 3'(i)) && (!bus.cpu_byte || odd_s);
        end
    end

    // Read mux and registered read data, held between reads.
    always_comb begin
        sel_csr_s  = 8'h00;
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (ch_s == 3'(i)) begin
                sel_csr_s  = csr_byte(ie_q[i], IN_MASK[i], dba_q[i], of_q[i], ena_q[i]);
                sel_data_s = data_q[i];
            end else begin
                sel_csr_s  = sel_csr_s;
                sel_data_s = sel_data_s;
            end
        end
        if (!rd_s) begin
            rdata_d = rdata_q;
        end else if (bus.cpu_byte) begin
            rdata_d = {8'h00, odd_s ? sel_data_s : sel_csr_s};
        end else begin
            rdata_d = {sel_data_s, sel_csr_s};
        end
    end

    // Per-channel flag and data update; hardware-set OF wins over a same-cycle CPU clear.
    always_comb begin
        ie_d       = ie_q;
        of_d       = of_q;
        ena_d      = ena_q;
        dba_d      = dba_q;
        data_d     = data_q;
        tx_valid_d = '0;
        rd_clr_s   = '0;
        dba_now_s  = dba_q;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (wr_s && csr_sel_s[i]) begin
                ie_d[i]  = csr_wbyte_s[0];
                ena_d[i] = csr_wbyte_s[4];
                of_d[i]  = of_q[i] & csr_wbyte_s[3];
            end else begin
                ie_d[i]  = ie_q[i];
                ena_d[i] = ena_q[i];
            end
            if (IN_MASK[i]) begin
                rd_clr_s[i] = rd_s && data_sel_s[i];
                dba_d[i]    = dba_q[i] & ~rd_clr_s[i];
                if (bus.dev_rx_valid[i] && ena_q[i]) begin
                    data_d[i] = bus.dev_rx_data[8*i +: 8];
                    dba_d[i]  = 1'b1;
                    of_d[i]   = of_d[i] | (dba_q[i] & ~rd_clr_s[i]);
                end else begin
                    data_d[i] = data_q[i];
                end
            end else begin
                dba_now_s[i] = dba_q[i] | bus.dev_tx_done[i];
                dba_d[i]     = dba_now_s[i];
                if (wr_s && data_sel_s[i]) begin
                    data_d[i] = data_wbyte_s;
                    if (ena_q[i]) begin
                        tx_valid_d[i] = 1'b1;
                        of_d[i]       = of_d[i] | ~dba_now_s[i];
                        dba_d[i]      = 1'b0;
                    end else begin
                        tx_valid_d[i] = 1'b0;
                    end
                end else begin
                    data_d[i] = data_q[i];
                end
            end
        end
    end

    // Interrupt request: level of any enabled ready channel, vector of the lowest one.
    always_comb begin
        req_s      = ie_q & ena_q & dba_q;
        irq_d      = |req_s;
        irq_vect_d = irq_vect_q;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                irq_vect_d = 3'(i);
            end else begin
                irq_vect_d = irq_vect_d;
            end
        end
    end

    // Transmit data is only meaningful on output channels.
    always_comb begin
        tx_data_s = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (IN_MASK[i]) begin
                tx_data_s[8*i +: 8] = 8'h00;
            end else begin
                tx_data_s[8*i +: 8] = data_q[i];
            end
        end
    end

    // State registers; reset drops any pending tx pulse and ignores concurrent tx_done.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ie_q       <= '0;
            of_q       <= '0;
            ena_q      <= '1;
            dba_q      <= ~IN_MASK[NUM_DEV-1:0];
            data_q     <= '0;
            tx_valid_q <= '0;
            rdata_q    <= 16'h0000;
            irq_q      <= 1'b0;
            irq_vect_q <= 3'd0;
        end else begin
            ie_q       <= ie_d;
            of_q       <= of_d;
            ena_q      <= ena_d;
            dba_q      <= dba_d;
            data_q     <= data_d;
            tx_valid_q <= tx_valid_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            irq_vect_q <= irq_vect_d;
        end
    end

    assign bus.cpu_hit      = hit_s;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.dev_tx_valid = tx_valid_q;
    assign bus.dev_tx_data  = tx_data_s;
    assign bus.irq          = irq_q;
    assign bus.irq_vect     = irq_vect_q;

endmodule
